// File: rtl/decode_hazard_stage_pkg.sv
`default_nettype none
// =====================================================================
// Module : decode_hazard_stage_pkg
// Brief  : Opcode/funct constants, ctrl bit indices, FSM codes, decoders
// Rev    : 1.0  initial release
// =====================================================================
package decode_hazard_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_MUL   = 6'h18;

  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_BYTEWORD = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_IS_MULT  = 0;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_LD_STALL  = 2'd1;
  localparam logic [1:0] ST_MUL_STALL = 2'd2;

  // is_mult is added by the caller because it also depends on funct
  function automatic logic [7:0] ctrl_decode(input logic [5:0] op);
    logic [7:0] c;
    c = 8'h00;
    case (op)
      OP_RTYPE:          c[CTRL_REGWRITE] = 1'b1;
      OP_ADDI, OP_ADDIU: begin
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_ALUSRC]   = 1'b1;
      end
      OP_LW, OP_LB: begin
        c[CTRL_REGWRITE] = 1'b1;
        c[CTRL_MEMTOREG] = 1'b1;
        c[CTRL_MEMREAD]  = 1'b1;
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_BYTEWORD] = (op == OP_LB);
      end
      OP_SW, OP_SB: begin
        c[CTRL_MEMWRITE] = 1'b1;
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_BYTEWORD] = (op == OP_SB);
      end
      OP_BEQ, OP_BNE:    c[CTRL_BRANCH] = 1'b1;
      default:           c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs2(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_SB) ||
           (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_hazard_stage_hazard_unit.sv
`default_nettype none
// =====================================================================
// Module : hazard_unit
// Brief  : Load-use / mul-use RAW detection, mul scoreboard and stall FSM
// Rev    : 1.0  initial release
// =====================================================================
module hazard_unit
  import decode_hazard_stage_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int MUL_LAT = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid_i,
  input  logic [RA_W-1:0] rs1_i,
  input  logic [RA_W-1:0] rs2_i,
  input  logic            use_rs1_i,
  input  logic            use_rs2_i,
  input  logic            ex_valid_i,
  input  logic            ex_memread_i,
  input  logic [RA_W-1:0] ex_dest_i,
  input  logic            ex_stall_i,
  input  logic            flush_i,
  input  logic            mul_issue_i,
  input  logic [RA_W-1:0] mul_issue_dst_i,
  output logic            load_haz_o,
  output logic            mul_haz_o
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MUL_LAT - 1);

  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [RA_W-1:0]  mul_dst_q, mul_dst_d;
  logic [1:0]       state_q, state_d;

  always_comb begin
    load_haz_o = ex_valid_i && ex_memread_i && (ex_dest_i != '0) &&
                 ((use_rs1_i && (ex_dest_i == rs1_i)) ||
                  (use_rs2_i && (ex_dest_i == rs2_i)));
    mul_haz_o  = (mul_cnt_q != '0) && (mul_dst_q != '0) &&
                 ((use_rs1_i && (mul_dst_q == rs1_i)) ||
                  (use_rs2_i && (mul_dst_q == rs2_i)));
  end

  // A newer mul always reloads the counter and takes over mul_dst
  always_comb begin
    mul_cnt_d = mul_cnt_q;
    mul_dst_d = mul_dst_q;
    if (!ex_stall_i) begin
      if (mul_issue_i) begin
        mul_cnt_d = CNT_RELOAD;
        mul_dst_d = mul_issue_dst_i;
      end else if (mul_cnt_q != '0) begin
        mul_cnt_d = mul_cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ex_stall_i) begin
      if (flush_i) begin
        state_d = ST_RUN;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (in_valid_i && mul_haz_o)       state_d = ST_MUL_STALL;
            else if (in_valid_i && load_haz_o) state_d = ST_LD_STALL;
          end
          ST_LD_STALL:  state_d = ST_RUN;
          ST_MUL_STALL: if (mul_cnt_q <= CNT_W'(1)) state_d = ST_RUN;
          default:      state_d = ST_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_cnt_q <= '0;
      mul_dst_q <= '0;
      state_q   <= ST_RUN;
    end else begin
      mul_cnt_q <= mul_cnt_d;
      mul_dst_q <= mul_dst_d;
      state_q   <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_hazard_stage.sv
`default_nettype none
// =====================================================================
// Module : decode_hazard_stage
// Brief  : ID stage: decode, regfile addressing, ID/EX regs, RAW stalls
// Rev    : 1.0  initial release
// =====================================================================
module decode_hazard_stage
  import decode_hazard_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int REG_W   = 32,
  parameter int RA_W    = 5,
  parameter int IMM_W   = 21,
  parameter int MUL_LAT = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               ex_stall,
  input  logic               flush,
  output logic [RA_W-1:0]    src_reg1,
  output logic [RA_W-1:0]    src_reg2,
  input  logic [REG_W-1:0]   rin_reg1,
  input  logic [REG_W-1:0]   rin_reg2,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [5:0]         op_code,
  output logic [5:0]         funct_code,
  output logic [RA_W-1:0]    out_addr_reg1,
  output logic [RA_W-1:0]    out_addr_reg2,
  output logic [RA_W-1:0]    dest_reg,
  output logic [REG_W-1:0]   rout_reg1,
  output logic [REG_W-1:0]   rout_reg2,
  output logic [ADDR_W-1:0]  mimmediat,
  output logic [7:0]         ctrl,
  output logic [ADDR_W-1:0]  jump_addr,
  output logic               is_jump,
  output logic               hold_fetch
);

  logic [5:0]        opcode, funct;
  logic [RA_W-1:0]   rd, dest_dec;
  logic [7:0]        ctrl_dec;
  logic [ADDR_W-1:0] imm_ext;
  logic              load_haz, mul_haz, hazard, accept;

  assign opcode   = instruction[31:26];
  assign funct    = instruction[5:0];
  assign src_reg1 = instruction[25:21];
  assign src_reg2 = instruction[20:16];
  assign rd       = instruction[15:11];

  always_comb begin
    ctrl_dec = ctrl_decode(opcode);
    ctrl_dec[CTRL_IS_MULT] = (opcode == OP_RTYPE) && (funct == FN_MUL);
    dest_dec = (opcode == OP_RTYPE) ? rd : src_reg2;
    if (opcode == OP_ADDIU)
      imm_ext = {{(ADDR_W-IMM_W){1'b0}}, instruction[IMM_W-1:0]};
    else
      imm_ext = {{(ADDR_W-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};
  end

  assign hazard     = load_haz || mul_haz;
  assign accept     = in_valid && !flush && !hazard;
  assign hold_fetch = ex_stall || (in_valid && !flush && hazard);
  assign is_jump    = in_valid && (opcode == OP_JUMP) && !flush && !hold_fetch;
  assign jump_addr  = (pc & {4'hF, {(ADDR_W-4){1'b0}}}) |
                      ADDR_W'({instruction[25:0], 2'b00});

  hazard_unit #(
    .RA_W    (RA_W),
    .MUL_LAT (MUL_LAT)
  ) u_hazard (
    .clk             (clk),
    .reset           (reset),
    .in_valid_i      (in_valid),
    .rs1_i           (src_reg1),
    .rs2_i           (src_reg2),
    .use_rs1_i       (opcode != OP_JUMP),
    .use_rs2_i       (uses_rs2(opcode)),
    .ex_valid_i      (out_valid),
    .ex_memread_i    (ctrl[CTRL_MEMREAD]),
    .ex_dest_i       (dest_reg),
    .ex_stall_i      (ex_stall),
    .flush_i         (flush),
    .mul_issue_i     (accept && ctrl_dec[CTRL_IS_MULT]),
    .mul_issue_dst_i (dest_dec),
    .load_haz_o      (load_haz),
    .mul_haz_o       (mul_haz)
  );

  // Bubbles only clear valid/ctrl; the payload fields keep their last value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      op_code       <= '0;
      funct_code    <= '0;
      out_addr_reg1 <= '0;
      out_addr_reg2 <= '0;
      dest_reg      <= '0;
      rout_reg1     <= '0;
      rout_reg2     <= '0;
      mimmediat     <= '0;
      ctrl          <= '0;
    end else if (!ex_stall) begin
      if (accept) begin
        out_valid     <= 1'b1;
        out_pc        <= pc;
        op_code       <= opcode;
        funct_code    <= funct;
        out_addr_reg1 <= src_reg1;
        out_addr_reg2 <= src_reg2;
        dest_reg      <= dest_dec;
        rout_reg1     <= rin_reg1;
        rout_reg2     <= rin_reg2;
        mimmediat     <= imm_ext;
        ctrl          <= ctrl_dec;
      end else begin
        out_valid <= 1'b0;
        ctrl      <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_hazard_stage.sv
`default_nettype none
// =====================================================================
// Module : tb_decode_hazard_stage
// Brief  : Directed self-checking bench for decode_hazard_stage
// Rev    : 1.0  initial release
// =====================================================================
module tb_decode_hazard_stage;
  import decode_hazard_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        ex_stall;
  logic        flush;
  logic [4:0]  src_reg1, src_reg2;
  logic [31:0] rin_reg1, rin_reg2;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [5:0]  op_code, funct_code;
  logic [4:0]  out_addr_reg1, out_addr_reg2, dest_reg;
  logic [31:0] rout_reg1, rout_reg2, mimmediat;
  logic [7:0]  ctrl;
  logic [31:0] jump_addr;
  logic        is_jump;
  logic        hold_fetch;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rin_reg1 = 32'hA000_0000 | 32'(src_reg1);
  assign rin_reg2 = 32'hB000_0000 | 32'(src_reg2);

  decode_hazard_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .pc            (pc),
    .instruction   (instruction),
    .ex_stall      (ex_stall),
    .flush         (flush),
    .src_reg1      (src_reg1),
    .src_reg2      (src_reg2),
    .rin_reg1      (rin_reg1),
    .rin_reg2      (rin_reg2),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .op_code       (op_code),
    .funct_code    (funct_code),
    .out_addr_reg1 (out_addr_reg1),
    .out_addr_reg2 (out_addr_reg2),
    .dest_reg      (dest_reg),
    .rout_reg1     (rout_reg1),
    .rout_reg2     (rout_reg2),
    .mimmediat     (mimmediat),
    .ctrl          (ctrl),
    .jump_addr     (jump_addr),
    .is_jump       (is_jump),
    .hold_fetch    (hold_fetch)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] ins);
    pc          = p;
    instruction = ins;
    in_valid    = 1'b1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; pc = '0; instruction = '0;
    ex_stall = 1'b0; flush = 1'b0;
    #3;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ctrl",  32'(ctrl), 32'd0);
    check_eq("rst_pc",    out_pc, 32'd0);
    check_eq("rst_hold",  32'(hold_fetch), 32'd0);
    check_eq("rst_state", 32'(dut.u_hazard.state_q), 32'(ST_RUN));
    #9 reset = 1'b1;
    tick();

    // Load-use: one bubble
    drive(32'h100, enc_i(OP_LW, 5'd1, 5'd3, 16'h0010));
    #1;
    check_eq("lw_src1", 32'(src_reg1), 32'd1);
    check_eq("lw_src2", 32'(src_reg2), 32'd3);
    check_eq("lw_hold", 32'(hold_fetch), 32'd0);
    tick();
    check_eq("lw_valid", 32'(out_valid), 32'd1);
    check_eq("lw_ctrl",  32'(ctrl), 32'h0000_00CA);
    check_eq("lw_dest",  32'(dest_reg), 32'd3);
    check_eq("lw_imm",   mimmediat, 32'h0003_0010);
    check_eq("lw_rdata", rout_reg1, 32'hA000_0001);
    drive(32'h104, enc_r(5'd3, 5'd5, 5'd4, 6'h20));
    #1;
    check_eq("ld_haz_hold", 32'(hold_fetch), 32'd1);
    tick();
    check_eq("ld_bubble",   32'(out_valid), 32'd0);
    check_eq("ld_bub_ctrl", 32'(ctrl), 32'd0);
    check_eq("ld_state",    32'(dut.u_hazard.state_q), 32'(ST_LD_STALL));
    #1;
    check_eq("ld_release",  32'(hold_fetch), 32'd0);
    tick();
    check_eq("add_valid", 32'(out_valid), 32'd1);
    check_eq("add_dest",  32'(dest_reg), 32'd4);
    check_eq("add_pc",    out_pc, 32'h104);
    check_eq("add_ctrl",  32'(ctrl), 32'h80);
    check_eq("add_rd2",   rout_reg2, 32'hB000_0005);

    // Mul-use: MUL_LAT-1 bubbles
    drive(32'h108, enc_r(5'd2, 5'd8, 5'd6, FN_MUL));
    tick();
    check_eq("mul_ctrl",  32'(ctrl), 32'h81);
    check_eq("mul_valid", 32'(out_valid), 32'd1);
    drive(32'h10C, enc_r(5'd6, 5'd1, 5'd7, 6'h20));
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("mul_hold", 32'(hold_fetch), 32'd1);
      tick();
      check_eq("mul_bubble", 32'(out_valid), 32'd0);
      if (i == 0) check_eq("mul_state", 32'(dut.u_hazard.state_q), 32'(ST_MUL_STALL));
    end
    check_eq("mul_state_end", 32'(dut.u_hazard.state_q), 32'(ST_RUN));
    #1;
    check_eq("mul_release", 32'(hold_fetch), 32'd0);
    tick();
    check_eq("mul_add_valid", 32'(out_valid), 32'd1);
    check_eq("mul_add_dest",  32'(dest_reg), 32'd7);
    check_eq("mul_add_pc",    out_pc, 32'h10C);

    // Register 0 never hazards
    drive(32'h110, enc_i(OP_LW, 5'd1, 5'd0, 16'h0004));
    tick();
    check_eq("lw0_dest", 32'(dest_reg), 32'd0);
    drive(32'h114, enc_r(5'd0, 5'd0, 5'd4, 6'h20));
    #1;
    check_eq("r0_hold", 32'(hold_fetch), 32'd0);
    tick();
    check_eq("r0_valid", 32'(out_valid), 32'd1);
    check_eq("r0_pc",    out_pc, 32'h114);

    // Immediate extension and EX stall
    drive(32'h118, enc_i(OP_ADDIU, 5'd1, 5'd17, 16'h8001));
    tick();
    check_eq("addiu_imm",  mimmediat, 32'h0011_8001);
    check_eq("addiu_ctrl", 32'(ctrl), 32'h82);
    check_eq("addiu_dest", 32'(dest_reg), 32'd17);
    drive(32'h11C, enc_i(OP_SW, 5'd2, 5'd17, 16'h8001));
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_hold", 32'(hold_fetch), 32'd1);
      tick();
      check_eq("stall_pc",    out_pc, 32'h118);
      check_eq("stall_imm",   mimmediat, 32'h0011_8001);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_ctrl",  32'(ctrl), 32'h82);
    end
    ex_stall = 1'b0;
    #1;
    check_eq("unstall_hold", 32'(hold_fetch), 32'd0);
    tick();
    check_eq("sw_pc",   out_pc, 32'h11C);
    check_eq("sw_ctrl", 32'(ctrl), 32'h12);
    check_eq("sw_imm",  mimmediat, 32'hFFF1_8001);
    in_valid = 1'b0;
    #1;
    check_eq("idle_hold", 32'(hold_fetch), 32'd0);
    tick();
    check_eq("no_dup", 32'(out_valid), 32'd0);

    // Jump address, flush gating, unknown opcode
    drive(32'h3000_0010, {OP_JUMP, 26'h012_3456});
    #1;
    check_eq("jump_addr", jump_addr, 32'h3048_D158);
    check_eq("is_jump",   32'(is_jump), 32'd1);
    flush = 1'b1;
    #1;
    check_eq("jump_flushed", 32'(is_jump), 32'd0);
    flush = 1'b0;
    drive(32'h120, {6'h3F, 26'h0});
    tick();
    check_eq("unk_ctrl",  32'(ctrl), 32'd0);
    check_eq("unk_valid", 32'(out_valid), 32'd1);

    // Flush during LD_STALL
    drive(32'h124, enc_i(OP_LW, 5'd1, 5'd3, 16'h0010));
    tick();
    drive(32'h128, enc_r(5'd3, 5'd5, 5'd4, 6'h20));
    tick();
    check_eq("fl_state_ld", 32'(dut.u_hazard.state_q), 32'(ST_LD_STALL));
    flush = 1'b1;
    #1;
    check_eq("fl_hold", 32'(hold_fetch), 32'd0);
    tick();
    check_eq("fl_valid", 32'(out_valid), 32'd0);
    check_eq("fl_ctrl",  32'(ctrl), 32'd0);
    check_eq("fl_state", 32'(dut.u_hazard.state_q), 32'(ST_RUN));
    flush = 1'b0;

    // Reset during MUL_STALL
    drive(32'h12C, enc_r(5'd2, 5'd8, 5'd6, FN_MUL));
    tick();
    drive(32'h130, enc_r(5'd6, 5'd1, 5'd7, 6'h20));
    tick();
    check_eq("mr_state", 32'(dut.u_hazard.state_q), 32'(ST_MUL_STALL));
    check_eq("mr_pc_before", out_pc, 32'h12C);
    #2 reset = 1'b0;
    #1;
    check_eq("mr_pc",    out_pc, 32'd0);
    check_eq("mr_dest",  32'(dest_reg), 32'd0);
    check_eq("mr_ctrl",  32'(ctrl), 32'd0);
    check_eq("mr_hold",  32'(hold_fetch), 32'd0);
    check_eq("mr_state_run", 32'(dut.u_hazard.state_q), 32'(ST_RUN));
    #2 reset = 1'b1;
    #1;
    check_eq("post_rst_hold", 32'(hold_fetch), 32'd0);
    tick();
    check_eq("post_rst_valid", 32'(out_valid), 32'd1);
    check_eq("post_rst_dest",  32'(dest_reg), 32'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
